// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory read arbiter.
// Stats outputs on the top are enabled by defining IMEM_ARB_STATS_EN.
package imem_arb_pkg;
  localparam int IMEM_WORD_W        = 32;
  localparam int DEFAULT_ADDR_DEPTH = 14;

  typedef enum logic {NORMAL = 1'b0, FORCE_DB = 1'b1} arb_state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_DB = 1'b1} port_id_t;
endpackage

// File: rtl/imem_resp_slot.sv
// Single-entry registered response buffer with valid/ready handoff and flush.
module imem_resp_slot
  import imem_arb_pkg::*;
#(
  parameter int W = IMEM_WORD_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  input  logic         i_flush,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Flush beats a handshake; a load with ready replaces data back-to-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/imem_read_arbiter.sv
// Two-port (fetch/debug) arbiter for one combinational instruction-memory read port.
// Defining IMEM_ARB_STATS_EN adds grant/conflict counters as outputs.
module imem_read_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_DEPTH   = DEFAULT_ADDR_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IF_REQ,
  input  logic [ADDR_DEPTH-1:0]  IF_ADDR,
  output logic                   IF_GNT,
  input  logic                   IF_FLUSH,
  output logic                   IF_RVALID,
  output logic [IMEM_WORD_W-1:0] IF_RDATA,
  input  logic                   IF_RREADY,
  input  logic                   DB_REQ,
  input  logic [ADDR_DEPTH-1:0]  DB_ADDR,
  output logic                   DB_GNT,
  output logic                   DB_RVALID,
  output logic [IMEM_WORD_W-1:0] DB_RDATA,
  input  logic                   DB_RREADY,
  output logic                   IMEM_RDEN,
  output logic [ADDR_DEPTH-1:0]  IMEM_ADDR,
  input  logic [IMEM_WORD_W-1:0] IMEM_DATA
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]            IF_GNT_CNT,
  output logic [31:0]            DB_GNT_CNT,
  output logic [31:0]            CONFLICT_CNT
`endif
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIMIT);

  // Handshake: a response moves when RVALID && RREADY at a rising edge;
  // a grant means the request is accepted in the same cycle it is seen.
  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_if_elig, w_db_elig, w_if_gnt, w_db_gnt;
  port_id_t         w_sel;

  assign w_if_elig = IF_REQ && !IF_FLUSH && (!IF_RVALID || IF_RREADY);
  assign w_db_elig = DB_REQ && (!DB_RVALID || DB_RREADY);

  always_comb begin
    w_if_gnt = 1'b0;
    w_db_gnt = 1'b0;
    if (!RST) begin
      if (w_if_elig && w_db_elig) begin
        if (r_state == FORCE_DB) w_db_gnt = 1'b1;
        else                     w_if_gnt = 1'b1;
      end else if (w_if_elig) begin
        w_if_gnt = 1'b1;
      end else if (w_db_elig) begin
        w_db_gnt = 1'b1;
      end
    end
    w_sel = w_db_gnt ? PORT_DB : PORT_IF;
  end

  assign IF_GNT    = w_if_gnt;
  assign DB_GNT    = w_db_gnt;
  assign IMEM_RDEN = w_if_gnt | w_db_gnt;
  assign IMEM_ADDR = !(w_if_gnt | w_db_gnt) ? '0 :
                     (w_sel == PORT_DB) ? DB_ADDR : IF_ADDR;

  // Switching on the next count lets the forced grant land on the very
  // cycle the counter reaches the limit.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (!DB_REQ || w_db_gnt)            w_cnt_nxt = '0;
    else if (w_db_elig && (r_cnt < LIM)) w_cnt_nxt = r_cnt + CNT_W'(1);
    if (r_state == NORMAL) begin
      if (w_cnt_nxt == LIM) w_state_nxt = FORCE_DB;
    end else if (w_db_gnt || !DB_REQ) begin
      w_state_nxt = NORMAL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  imem_resp_slot #(.W(IMEM_WORD_W)) u_if_slot (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_if_gnt),
    .i_data  (IMEM_DATA),
    .i_ready (IF_RREADY),
    .i_flush (IF_FLUSH),
    .o_valid (IF_RVALID),
    .o_data  (IF_RDATA)
  );

  imem_resp_slot #(.W(IMEM_WORD_W)) u_db_slot (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_db_gnt),
    .i_data  (IMEM_DATA),
    .i_ready (DB_RREADY),
    .i_flush (1'b0),
    .o_valid (DB_RVALID),
    .o_data  (DB_RDATA)
  );

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] r_if_gnt_cnt, r_db_gnt_cnt, r_conflict_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_if_gnt_cnt   <= '0;
      r_db_gnt_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_if_gnt)              r_if_gnt_cnt   <= r_if_gnt_cnt + 32'd1;
      if (w_db_gnt)              r_db_gnt_cnt   <= r_db_gnt_cnt + 32'd1;
      if (w_if_elig && w_db_elig) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign IF_GNT_CNT   = r_if_gnt_cnt;
  assign DB_GNT_CNT   = r_db_gnt_cnt;
  assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule

// File: doc/imem_read_arbiter.md
Name: imem_read_arbiter

Overview:
- Shares the single combinational instruction-memory read port between two requesters: the core fetch stage (IF) and the debug/loader read port (DB).
- Arbitrates each cycle and drives the memory's read enable and address.
- Returns data through a one-entry registered response buffer per port, using valid/ready backpressure.
- Fixed priority to IF, with a starvation guard that forces a DB grant. Sits between the fetch unit, the debug module and the instruction memory.

Parameters:
- ADDR_DEPTH, 14, word-address width; must match the instruction memory.
- STARVE_LIMIT, 4, consecutive cycles DB may be eligible but denied before its grant is forced; must be ≥1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-high reset
- IF_REQ  input  1  fetch read request
- IF_ADDR  input  ADDR_DEPTH  fetch word address
- IF_GNT  output  1  fetch request accepted this cycle (combinational)
- IF_FLUSH  input  1  discard any fetch response; block the fetch grant this cycle
- IF_RVALID  output  1  fetch response valid
- IF_RDATA  output  32  fetch response data
- IF_RREADY  input  1  fetch consumer accepts response
- DB_REQ  input  1  debug read request
- DB_ADDR  input  ADDR_DEPTH  debug word address
- DB_GNT  output  1  debug request accepted (combinational)
- DB_RVALID  output  1  debug response valid
- DB_RDATA  output  32  debug response data
- DB_RREADY  input  1  debug consumer accepts response
- IMEM_RDEN  output  1  memory read enable
- IMEM_ADDR  output  ADDR_DEPTH  memory address
- IMEM_DATA  input  32  memory read data (combinational from IMEM_ADDR)

Behaviour:

Reset values
- RST high at a clock edge: IF_RVALID, DB_RVALID, IF_RDATA and DB_RDATA are 0.
- Starvation counter is 0 and the FSM is in NORMAL.
- During reset cycles IF_GNT, DB_GNT and IMEM_RDEN are 0.

Eligibility
- IF is eligible when IF_REQ && !IF_FLUSH && (!IF_RVALID || IF_RREADY).
- DB is eligible when DB_REQ && (!DB_RVALID || DB_RREADY).

FSM
- States are NORMAL and FORCE_DB.
- NORMAL: if both ports are eligible, IF wins.
- FORCE_DB: if both ports are eligible, DB wins.
- In either state, a sole eligible port wins.
- NORMAL → FORCE_DB when the starvation counter reaches STARVE_LIMIT.
- FORCE_DB → NORMAL on the DB grant. If DB_REQ drops first, return to NORMAL.

Starvation counter
- Width is $clog2(STARVE_LIMIT+1).
- Increments when DB is eligible and not granted; saturates at STARVE_LIMIT.
- Clears on a DB grant or when DB_REQ is low.

Memory drive
- At most one grant per cycle.
- IMEM_RDEN = IF_GNT | DB_GNT.
- IMEM_ADDR is the granted port's address, or 0 when nothing is granted.

Response timing
- Latency is 1 cycle: at the edge after a grant, the granted port's RDATA <= IMEM_DATA and RVALID <= 1.
- The response holds, stable, until RREADY.
- On the RREADY handshake with no new grant, RVALID <= 0. RDATA keeps its last value.
- RREADY with a simultaneous grant to the same port: new data replaces the old back-to-back; RVALID stays 1.
- Full throughput: 1 read per cycle per port when uncontended and RREADY is held high.

Flush
- IF_FLUSH high at an edge clears IF_RVALID regardless of IF_RREADY. Flush takes precedence over a handshake.
- No IF grant is issued in a flush cycle, so the address for the redirect is presented the next cycle.

Other rules
- No RREADY means that port stalls; the other port continues unaffected.
- RST mid-operation: pending responses are dropped with no partial state retained. Requesters must reissue.
- Addresses are passed through unmodified; no range check (the memory wraps naturally within ADDR_DEPTH).

Optional Feature:
Macro IMEM_ARB_STATS_EN.
- Defined: adds three 32-bit outputs.
  - IF_GNT_CNT increments on each IF grant.
  - DB_GNT_CNT increments on each DB grant.
  - CONFLICT_CNT increments in each cycle where both ports are eligible.
  - All three reset to 0 on RST and wrap at 2^32.
- Undefined: these ports and their logic are absent; the module is otherwise identical.

Decomposition:
- Package imem_arb_pkg holds:
  - arb_state_t enum {NORMAL, FORCE_DB}
  - port_id_t enum {PORT_IF, PORT_DB}
  - IMEM_WORD_W = 32
  - DEFAULT_ADDR_DEPTH = 14
- One sub-module, imem_resp_slot: a single-entry response register handling valid/ready/flush, instantiated once per port (flush tied 0 for DB).

Test Plan:
1. Reset: assert RST 2 cycles with IF_REQ=1 → IF_GNT=0, IMEM_RDEN=0, both RVALID=0. After release, IF_GNT=1 the same cycle; IF_RVALID=1 one cycle later with IF_RDATA=mem[IF_ADDR].
2. Streaming: IF reads addresses 0..7 back-to-back with IF_RREADY=1 → 8 responses on 8 consecutive cycles, data matching, no bubbles.
3. Starvation: IF_REQ and DB_REQ held 1, STARVE_LIMIT=4 → IF granted cycles 0–3, DB granted cycle 4 (DB_ADDR=0x123 returns mem[0x123]), then IF resumes.
4. Backpressure: DB response pending with DB_RREADY=0 for 5 cycles → DB_RDATA stable, DB_GNT=0 throughout, IF grants continue every cycle.
5. Flush: IF response pending, assert IF_FLUSH with IF_REQ=1 → IF_GNT=0 that cycle, IF_RVALID=0 next cycle. The following IF request to 0x040 returns mem[0x040].
6. Stats (IMEM_ARB_STATS_EN): scenario 3 run for 10 cycles → IF_GNT_CNT=8, DB_GNT_CNT=2, CONFLICT_CNT=10.
